// File: rtl/gmii_rx_if.sv
// GMII receive bus plus the deframed video/audio outputs of gmii_rx.
// slave is the deframer side, master is the PHY/consumer side.
interface gmii_rx_if;
  logic        id;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic        pkt_type;
  logic [15:0] vid_hdr;
  logic        vid_hdr_valid;
  logic        vid_wr_en;
  logic [15:0] vid_din;
  logic        aux_wr_en;
  logic [7:0]  aux_din;
  logic        frame_ok;
  logic        frame_err;

  modport slave (
    input  id, rx_dv, rx_er, rxd,
    output pkt_type, vid_hdr, vid_hdr_valid, vid_wr_en, vid_din,
           aux_wr_en, aux_din, frame_ok, frame_err
  );

  modport master (
    output id, rx_dv, rx_er, rxd,
    input  pkt_type, vid_hdr, vid_hdr_valid, vid_wr_en, vid_din,
           aux_wr_en, aux_din, frame_ok, frame_err
  );
endinterface

// File: rtl/gmii_rx.sv
// GMII deframer: strips preamble/Eth/IPv4/UDP headers, splits video pixel pairs
// from audio bytes, and reports frame good/bad from the Ethernet FCS.
//
// state      | meaning
// IDLE       | waiting for a preamble byte (after rx_dv has been low once)
// PRE        | preamble, waiting for SFD
// ETH/IP/UDP | header bytes being matched
// PCKTIDNT   | packet identifier byte: video or audio
// DATA_RESOL | video resolution header leaving the delay line
// PAYLOAD    | pixel pairs or audio bytes leaving the delay line
// DROP       | rejected frame, wait for rx_dv low
// END        | frame_ok / frame_err pulse
module gmii_rx #(
  parameter logic [47:0] my_mac    = 48'h002345678902,
  parameter logic [15:0] ip_type   = 16'h0800,
  parameter logic [7:0]  ip_prot   = 8'h11,
  parameter logic [15:0] udp_dport = 16'h3039,
  parameter logic [10:0] video_len = 11'd1280
) (
  input logic      rx_clk,
  input logic      sys_rst,
  gmii_rx_if.slave bus
);
  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_PRE        = 4'd1;
  localparam logic [3:0] S_ETH        = 4'd2;
  localparam logic [3:0] S_IP         = 4'd3;
  localparam logic [3:0] S_UDP        = 4'd4;
  localparam logic [3:0] S_PCKTIDNT   = 4'd5;
  localparam logic [3:0] S_DATA_RESOL = 4'd6;
  localparam logic [3:0] S_PAYLOAD    = 4'd7;
  localparam logic [3:0] S_DROP       = 4'd8;
  localparam logic [3:0] S_END        = 4'd9;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // Byte-wide CRC-32, data bits fed LSB first into an MSB-first register.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    end
    return r;
  endfunction

  logic [3:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic        wait_q, wait_d;
  logic [31:0] dl_q, dl_d;
  logic [2:0]  fill_q, fill_d;
  logic        hdr_seen_q, hdr_seen_d;
  logic [7:0]  y_q, y_d;
  logic [10:0] vid_cnt_q, vid_cnt_d;
  logic        pkt_type_q, pkt_type_d;
  logic [15:0] vid_hdr_q, vid_hdr_d;
  logic        vid_hdr_valid_q, vid_hdr_valid_d;
  logic        vid_wr_en_q, vid_wr_en_d;
  logic [15:0] vid_din_q, vid_din_d;
  logic        aux_wr_en_q, aux_wr_en_d;
  logic [7:0]  aux_din_q, aux_din_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;

  logic [7:0]  da_lo, da_b, pop_byte;
  logic        in_frame, pop;

  assign da_lo    = my_mac[7:0] - {7'd0, bus.id};
  assign pop_byte = dl_q[31:24];

  always_comb begin
    case (cnt_q[2:0])
      3'd0:    da_b = my_mac[47:40];
      3'd1:    da_b = my_mac[39:32];
      3'd2:    da_b = my_mac[31:24];
      3'd3:    da_b = my_mac[23:16];
      3'd4:    da_b = my_mac[15:8];
      default: da_b = da_lo;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    crc_d           = crc_q;
    err_d           = err_q;
    wait_d          = wait_q;
    dl_d            = dl_q;
    fill_d          = fill_q;
    hdr_seen_d      = hdr_seen_q;
    y_d             = y_q;
    vid_cnt_d       = vid_cnt_q;
    pkt_type_d      = pkt_type_q;
    vid_hdr_d       = vid_hdr_q;
    vid_hdr_valid_d = 1'b0;
    vid_wr_en_d     = 1'b0;
    vid_din_d       = vid_din_q;
    aux_wr_en_d     = 1'b0;
    aux_din_d       = aux_din_q;
    frame_ok_d      = 1'b0;
    frame_err_d     = 1'b0;
    pop             = 1'b0;
    in_frame        = state_q inside {S_ETH, S_IP, S_UDP, S_PCKTIDNT, S_DATA_RESOL, S_PAYLOAD};

    if (!bus.rx_dv) wait_d = 1'b0;

    if (in_frame && bus.rx_dv) begin
      crc_d = crc_next(crc_q, bus.rxd);
      cnt_d = cnt_q + 5'd1;
      if (bus.rx_er) err_d = 1'b1;
    end

    // Four-byte delay line keeps the FCS away from the outputs.
    if ((state_q == S_DATA_RESOL || state_q == S_PAYLOAD) && bus.rx_dv) begin
      dl_d = {dl_q[23:0], bus.rxd};
      if (fill_q == 3'd4) pop = 1'b1;
      else                fill_d = fill_q + 3'd1;
    end

    case (state_q)
      S_IDLE, S_END: begin
        if (bus.rx_dv && bus.rxd == 8'h55 && !wait_q) state_d = S_PRE;
        else                                         state_d = S_IDLE;
      end
      S_PRE: begin
        if (!bus.rx_dv) state_d = S_IDLE;
        else if (bus.rxd == 8'hd5) begin
          state_d    = S_ETH;
          cnt_d      = 5'd0;
          crc_d      = 32'hFFFFFFFF;
          err_d      = 1'b0;
          fill_d     = 3'd0;
          hdr_seen_d = 1'b0;
          vid_cnt_d  = 11'd0;
        end else if (bus.rxd != 8'h55) state_d = S_DROP;
      end
      S_ETH: begin
        if (!bus.rx_dv) begin
          // Only a frame whose DA already matched reports an abort.
          if (cnt_q >= 5'd6) begin
            state_d     = S_END;
            frame_err_d = 1'b1;
          end else state_d = S_IDLE;
        end else if ((cnt_q < 5'd6 && bus.rxd != da_b) ||
                     (cnt_q == 5'd12 && bus.rxd != ip_type[15:8]) ||
                     (cnt_q == 5'd13 && bus.rxd != ip_type[7:0])) begin
          state_d = S_DROP;
        end else if (cnt_q == 5'd13) begin
          state_d = S_IP;
          cnt_d   = 5'd0;
        end
      end
      S_IP: begin
        if (!bus.rx_dv) begin
          state_d     = S_END;
          frame_err_d = 1'b1;
        end else if ((cnt_q == 5'd0 && bus.rxd != 8'h45) ||
                     (cnt_q == 5'd9 && bus.rxd != ip_prot)) begin
          state_d = S_DROP;
        end else if (cnt_q == 5'd19) begin
          state_d = S_UDP;
          cnt_d   = 5'd0;
        end
      end
      S_UDP: begin
        if (!bus.rx_dv) begin
          state_d     = S_END;
          frame_err_d = 1'b1;
        end else if ((cnt_q == 5'd2 && bus.rxd != udp_dport[15:8]) ||
                     (cnt_q == 5'd3 && bus.rxd != udp_dport[7:0])) begin
          state_d = S_DROP;
        end else if (cnt_q == 5'd7) begin
          state_d = S_PCKTIDNT;
          cnt_d   = 5'd0;
        end
      end
      S_PCKTIDNT: begin
        if (!bus.rx_dv) begin
          state_d     = S_END;
          frame_err_d = 1'b1;
        end else if (bus.rxd == 8'h00) begin
          state_d    = S_DATA_RESOL;
          pkt_type_d = 1'b0;
        end else if (bus.rxd == 8'h01) begin
          state_d    = S_PAYLOAD;
          pkt_type_d = 1'b1;
        end else state_d = S_DROP;
      end
      S_DATA_RESOL: begin
        if (!bus.rx_dv) begin
          state_d     = S_END;
          frame_err_d = 1'b1;
        end else if (pop) begin
          if (!hdr_seen_q) begin
            y_d        = pop_byte;
            hdr_seen_d = 1'b1;
          end else begin
            vid_hdr_d       = {y_q, pop_byte};
            vid_hdr_valid_d = 1'b1;
            state_d         = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!bus.rx_dv) begin
          state_d = S_END;
          if (crc_q == CRC_RESIDUE && !err_q && (pkt_type_q || vid_cnt_q == video_len))
            frame_ok_d = 1'b1;
          else
            frame_err_d = 1'b1;
        end else if (pop) begin
          if (pkt_type_q) begin
            aux_wr_en_d = 1'b1;
            aux_din_d   = pop_byte;
          end else if (vid_cnt_q < video_len) begin
            vid_cnt_d = vid_cnt_q + 11'd1;
            if (!vid_cnt_q[0]) y_d = pop_byte;
            else begin
              vid_wr_en_d = 1'b1;
              vid_din_d   = {y_q, pop_byte};
            end
          end
        end
      end
      S_DROP: begin
        if (!bus.rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 5'd0;
      crc_q           <= 32'd0;
      err_q           <= 1'b0;
      wait_q          <= 1'b1;
      dl_q            <= 32'd0;
      fill_q          <= 3'd0;
      hdr_seen_q      <= 1'b0;
      y_q             <= 8'd0;
      vid_cnt_q       <= 11'd0;
      pkt_type_q      <= 1'b0;
      vid_hdr_q       <= 16'd0;
      vid_hdr_valid_q <= 1'b0;
      vid_wr_en_q     <= 1'b0;
      vid_din_q       <= 16'd0;
      aux_wr_en_q     <= 1'b0;
      aux_din_q       <= 8'd0;
      frame_ok_q      <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      crc_q           <= crc_d;
      err_q           <= err_d;
      wait_q          <= wait_d;
      dl_q            <= dl_d;
      fill_q          <= fill_d;
      hdr_seen_q      <= hdr_seen_d;
      y_q             <= y_d;
      vid_cnt_q       <= vid_cnt_d;
      pkt_type_q      <= pkt_type_d;
      vid_hdr_q       <= vid_hdr_d;
      vid_hdr_valid_q <= vid_hdr_valid_d;
      vid_wr_en_q     <= vid_wr_en_d;
      vid_din_q       <= vid_din_d;
      aux_wr_en_q     <= aux_wr_en_d;
      aux_din_q       <= aux_din_d;
      frame_ok_q      <= frame_ok_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign bus.pkt_type      = pkt_type_q;
  assign bus.vid_hdr       = vid_hdr_q;
  assign bus.vid_hdr_valid = vid_hdr_valid_q;
  assign bus.vid_wr_en     = vid_wr_en_q;
  assign bus.vid_din       = vid_din_q;
  assign bus.aux_wr_en     = aux_wr_en_q;
  assign bus.aux_din       = aux_din_q;
  assign bus.frame_ok      = frame_ok_q;
  assign bus.frame_err     = frame_err_q;
endmodule

// File: tb/tb_gmii_rx.sv
// Scoreboard bench for gmii_rx: frames are built in the bench, a frame-level
// reference model queues the expected outputs and a monitor compares them.
module tb_gmii_rx;
  localparam logic [47:0] MY_MAC = 48'h002345678902;

  logic rx_clk = 1'b0;
  logic sys_rst = 1'b1;
  gmii_rx_if bus ();

  gmii_rx dut (.rx_clk(rx_clk), .sys_rst(sys_rst), .bus(bus));

  always #4 rx_clk = ~rx_clk;

  int checks = 0, passed = 0;
  int cyc = 0;
  int n_hdr, n_vid, n_aux, n_ok, n_err, n_post;
  int t_put, t_wr;
  logic [15:0] first_din;
  bit sb_off = 0, post_rst = 0, lat_arm = 0, cur_id = 0;

  logic [7:0]  frm[$];
  logic [15:0] exp_hdr[$], exp_vid[$];
  logic [7:0]  exp_aux[$];
  logic [1:0]  exp_st[$];

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic unexp(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Standard reflected Ethernet FCS over frm[0..n-1].
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input bit vid, input logic [7:0] da_lo, input logic [15:0] dport,
                       input int npay, input bit incr, input logic [7:0] h0, input logic [7:0] h1);
    logic [47:0] mac;
    logic [31:0] f;
    mac = MY_MAC;
    frm.delete();
    for (int i = 0; i < 5; i++) frm.push_back(mac[47-8*i -: 8]);
    frm.push_back(da_lo);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom_range(0, 255)));
    frm.push_back(8'h08); frm.push_back(8'h00);
    for (int i = 0; i < 20; i++)
      frm.push_back(i == 0 ? 8'h45 : (i == 9 ? 8'h11 : 8'($urandom_range(0, 255))));
    frm.push_back(8'($urandom_range(0, 255))); frm.push_back(8'($urandom_range(0, 255)));
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    for (int i = 0; i < 4; i++) frm.push_back(8'($urandom_range(0, 255)));
    frm.push_back(vid ? 8'h00 : 8'h01);
    if (vid) begin frm.push_back(h0); frm.push_back(h1); end
    for (int i = 0; i < npay; i++) frm.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
    f = fcs_of(frm.size());
    frm.push_back(f[7:0]); frm.push_back(f[15:8]); frm.push_back(f[23:16]); frm.push_back(f[31:24]);
  endtask

  // Frame-level model: header acceptance, all but the last 4 sent bytes are
  // delivered, FCS recomputed over the sent bytes.
  task automatic model(input int nsent, input bit er);
    logic [47:0] mac;
    logic [7:0]  da_lo;
    logic [31:0] f;
    bit acc, good, in_pay;
    int cons, np;
    mac   = MY_MAC;
    da_lo = mac[7:0] - 8'(cur_id);
    acc   = 1;
    for (int i = 0; i < 5; i++) if (frm[i] != mac[47-8*i -: 8]) acc = 0;
    if (frm[5] != da_lo) acc = 0;
    if (frm[12] != 8'h08 || frm[13] != 8'h00) acc = 0;
    if (frm[14] != 8'h45 || frm[23] != 8'h11) acc = 0;
    if (frm[36] != 8'h30 || frm[37] != 8'h39) acc = 0;
    if (frm[42] > 8'h01) acc = 0;
    if (!acc) return;
    cons = nsent - 43 - 4;
    if (cons < 0) cons = 0;
    f    = fcs_of(nsent - 4);
    good = !er && ({frm[nsent-1], frm[nsent-2], frm[nsent-3], frm[nsent-4]} == f);
    if (frm[42] == 8'h01) begin
      in_pay = 1;
      for (int i = 0; i < cons; i++) exp_aux.push_back(frm[43+i]);
    end else begin
      in_pay = (cons >= 2);
      if (in_pay) exp_hdr.push_back({frm[43], frm[44]});
      np = cons - 2;
      if (np > 1280) np = 1280;
      for (int i = 0; i + 1 < np; i += 2) exp_vid.push_back({frm[45+i], frm[46+i]});
      if (np < 1280) good = 0;
    end
    exp_st.push_back((good && in_pay) ? 2'b01 : 2'b10);
  endtask

  task automatic drive(input int nsend, input int er_idx, input int rst_idx);
    bus.id = cur_id;
    for (int i = 0; i < 8; i++) begin
      bus.rx_dv = 1; bus.rx_er = 0; bus.rxd = (i == 7) ? 8'hd5 : 8'h55;
      @(posedge rx_clk); #1;
    end
    for (int i = 0; i < nsend; i++) begin
      bus.rxd   = frm[i];
      bus.rx_er = (i == er_idx);
      if (i == 46) t_put = cyc;
      if (i == rst_idx) sys_rst = 1;
      if (rst_idx >= 0 && i == rst_idx + 2) begin sys_rst = 0; post_rst = 1; end
      @(posedge rx_clk); #1;
      if (i == rst_idx)
        chk("outputs_after_reset", 32'(|{bus.pkt_type, bus.vid_hdr, bus.vid_hdr_valid, bus.vid_wr_en,
            bus.vid_din, bus.aux_wr_en, bus.aux_din, bus.frame_ok, bus.frame_err}), 32'd0);
    end
    bus.rx_dv = 0; bus.rx_er = 0; bus.rxd = 8'h00; sys_rst = 0;
    repeat (12) @(posedge rx_clk);
    #1;
  endtask

  task automatic clr();
    n_hdr = 0; n_vid = 0; n_aux = 0; n_ok = 0; n_err = 0; n_post = 0;
  endtask

  always @(negedge rx_clk) begin
    if (post_rst && (bus.vid_hdr_valid || bus.vid_wr_en || bus.aux_wr_en || bus.frame_ok || bus.frame_err))
      n_post++;
    if (bus.vid_hdr_valid) n_hdr++;
    if (bus.vid_wr_en) begin
      n_vid++;
      if (lat_arm) begin t_wr = cyc; first_din = bus.vid_din; lat_arm = 0; end
    end
    if (bus.aux_wr_en) n_aux++;
    if (bus.frame_ok) n_ok++;
    if (bus.frame_err) n_err++;
    if (!sb_off) begin
      if (bus.vid_hdr_valid) begin
        if (exp_hdr.size() == 0) unexp("vid_hdr", 32'(bus.vid_hdr));
        else chk("vid_hdr", 32'(bus.vid_hdr), 32'(exp_hdr.pop_front()));
      end
      if (bus.vid_wr_en) begin
        if (exp_vid.size() == 0) unexp("vid_din", 32'(bus.vid_din));
        else chk("vid_din", 32'(bus.vid_din), 32'(exp_vid.pop_front()));
      end
      if (bus.aux_wr_en) begin
        if (exp_aux.size() == 0) unexp("aux_din", 32'(bus.aux_din));
        else chk("aux_din", 32'(bus.aux_din), 32'(exp_aux.pop_front()));
      end
      if (bus.frame_ok || bus.frame_err) begin
        if (exp_st.size() == 0) unexp("frame_status", 32'({bus.frame_err, bus.frame_ok}));
        else chk("frame_status", 32'({bus.frame_err, bus.frame_ok}), 32'(exp_st.pop_front()));
      end
    end
  end

  initial begin
    int np;
    bit v;
    bus.id = 0; bus.rx_dv = 0; bus.rx_er = 0; bus.rxd = 8'h00;
    sys_rst = 1;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("reset_outputs", 32'(|{bus.pkt_type, bus.vid_hdr, bus.vid_hdr_valid, bus.vid_wr_en,
        bus.vid_din, bus.aux_wr_en, bus.aux_din, bus.frame_ok, bus.frame_err}), 32'd0);
    sys_rst = 0;
    @(posedge rx_clk); #1;

    // 1: clean video frame, incrementing payload
    cur_id = 0; clr(); lat_arm = 1;
    build(1, 8'h02, 16'h3039, 1280, 1, 8'h12, 8'h34);
    model(frm.size(), 0); drive(frm.size(), -1, -1);
    chk("t1_hdr_pulses", 32'(n_hdr), 32'd1);
    chk("t1_vid_writes", 32'(n_vid), 32'd640);
    chk("t1_first_vid_din", 32'(first_din), 32'h0001);
    chk("t1_latency", 32'(t_wr - t_put), 32'd5);
    chk("t1_frame_ok", 32'(n_ok), 32'd1);
    chk("t1_frame_err", 32'(n_err), 32'd0);

    // 2: same frame with one payload bit flipped after FCS
    clr();
    build(1, 8'h02, 16'h3039, 1280, 1, 8'h12, 8'h34);
    frm[45 + $urandom_range(0, 1279)] ^= 8'(1 << $urandom_range(0, 7));
    model(frm.size(), 0); drive(frm.size(), -1, -1);
    chk("t2_vid_writes", 32'(n_vid), 32'd640);
    chk("t2_frame_ok", 32'(n_ok), 32'd0);
    chk("t2_frame_err", 32'(n_err), 32'd1);

    // 3: audio frame, id=1
    cur_id = 1; clr();
    build(0, 8'h01, 16'h3039, 34, 0, 8'h00, 8'h00);
    model(frm.size(), 0); drive(frm.size(), -1, -1);
    chk("t3_aux_writes", 32'(n_aux), 32'd34);
    chk("t3_pkt_type", 32'(bus.pkt_type), 32'd1);
    chk("t3_frame_ok", 32'(n_ok), 32'd1);

    // 4: rejected headers (wrong DA for id=1, wrong UDP port)
    clr();
    build(1, 8'h02, 16'h3039, 1280, 0, 8'h12, 8'h34);
    model(frm.size(), 0); drive(frm.size(), -1, -1);
    cur_id = 0;
    build(0, 8'h02, 16'h3038, 34, 0, 8'h00, 8'h00);
    model(frm.size(), 0); drive(frm.size(), -1, -1);
    chk("t4_no_outputs", 32'(n_hdr + n_vid + n_aux + n_ok + n_err), 32'd0);

    // 5a: rx_er during video byte 100
    clr();
    build(1, 8'h02, 16'h3039, 1280, 0, 8'h05, 8'h00);
    model(frm.size(), 1); drive(frm.size(), 45 + 100, -1);
    chk("t5a_vid_writes", 32'(n_vid), 32'd640);
    chk("t5a_frame_ok", 32'(n_ok), 32'd0);
    chk("t5a_frame_err", 32'(n_err), 32'd1);

    // 5b: rx_dv dropped after 600 payload bytes
    clr();
    build(1, 8'h02, 16'h3039, 1280, 0, 8'h07, 8'h80);
    model(45 + 600, 0); drive(45 + 600, -1, -1);
    chk("t5b_vid_writes", 32'(n_vid), 32'd298);
    chk("t5b_frame_err", 32'(n_err), 32'd1);
    chk("t5b_frame_ok", 32'(n_ok), 32'd0);

    // 6: reset mid-payload, then a clean frame after the gap
    clr(); sb_off = 1;
    build(1, 8'h02, 16'h3039, 1280, 0, 8'h12, 8'h34);
    drive(frm.size(), -1, 45 + 100);
    chk("t6_outputs_after_reset", 32'(n_post), 32'd0);
    sb_off = 0; post_rst = 0; clr();
    build(1, 8'h02, 16'h3039, 1280, 0, 8'h0a, 8'h0b);
    model(frm.size(), 0); drive(frm.size(), -1, -1);
    chk("t6_frame_ok", 32'(n_ok), 32'd1);
    chk("t6_vid_writes", 32'(n_vid), 32'd640);

    // random frames: id, type, lengths, including video payload beyond video_len
    for (int k = 0; k < 4; k++) begin
      cur_id = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      np = v ? 1280 + $urandom_range(0, 5) : $urandom_range(1, 60);
      clr();
      build(v, 8'h02 - 8'(cur_id), 16'h3039, np, 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      model(frm.size(), 0); drive(frm.size(), -1, -1);
      chk("rnd_writes", 32'(v ? n_vid : n_aux), 32'(v ? 640 : np));
      chk("rnd_frame_ok", 32'(n_ok), 32'd1);
    end

    chk("queues_drained", 32'(exp_hdr.size() + exp_vid.size() + exp_aux.size() + exp_st.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
